// File: rtl/l2_port_arbiter.sv
// Shares the single L2 port between the I-cache and D-cache refill/write paths.
// Grants one requester at a time (round-robin on ties) and runs the L2 req/ack handshake.
module l2_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned BLOCK_W = 128,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_req,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic               i_stall,
    output logic               i_valid,
    output logic [BLOCK_W-1:0] i_block,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [WORD_W-1:0]  d_wdata,
    output logic               d_stall,
    output logic               d_valid,
    output logic [BLOCK_W-1:0] d_block,
    output logic               l2_req,
    output logic               l2_we,
    output logic [ADDR_W-1:0]  l2_addr,
    output logic [WORD_W-1:0]  l2_wdata,
    input  logic               l2_ack,
    input  logic [BLOCK_W-1:0] l2_rdata,
    output logic               err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t             state, state_nxt;
    logic               last_grant, last_grant_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               l2_req_nxt, l2_we_nxt, err_nxt;
    logic [ADDR_W-1:0]  l2_addr_nxt;
    logic [WORD_W-1:0]  l2_wdata_nxt;
    logic               i_valid_nxt, d_valid_nxt;
    logic [BLOCK_W-1:0] i_block_nxt, d_block_nxt;
    logic               grant_d, grant_i;

    // Stall holds each pipeline until its completion pulse
    assign i_stall = i_req & ~i_valid;
    assign d_stall = d_req & ~d_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
            cnt        <= '0;
            l2_req     <= 1'b0;
            l2_we      <= 1'b0;
            l2_addr    <= '0;
            l2_wdata   <= '0;
            i_valid    <= 1'b0;
            d_valid    <= 1'b0;
            i_block    <= '0;
            d_block    <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            cnt        <= cnt_nxt;
            l2_req     <= l2_req_nxt;
            l2_we      <= l2_we_nxt;
            l2_addr    <= l2_addr_nxt;
            l2_wdata   <= l2_wdata_nxt;
            i_valid    <= i_valid_nxt;
            d_valid    <= d_valid_nxt;
            i_block    <= i_block_nxt;
            d_block    <= d_block_nxt;
            err        <= err_nxt;
        end
    end

    // D wins a tie only when I was granted last
    assign grant_d = d_req & (~i_req | (last_grant == GRANT_I));
    assign grant_i = i_req & ~grant_d;

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        cnt_nxt        = cnt;
        l2_req_nxt     = l2_req;
        l2_we_nxt      = l2_we;
        l2_addr_nxt    = l2_addr;
        l2_wdata_nxt   = l2_wdata;
        i_valid_nxt    = 1'b0;
        d_valid_nxt    = 1'b0;
        i_block_nxt    = i_block;
        d_block_nxt    = d_block;
        err_nxt        = err;

        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt      = BUSY_D;
                    last_grant_nxt = GRANT_D;
                    cnt_nxt        = '0;
                    l2_req_nxt     = 1'b1;
                    l2_we_nxt      = d_we;
                    l2_addr_nxt    = d_addr;
                    l2_wdata_nxt   = d_wdata;
                end else if (grant_i) begin
                    state_nxt      = BUSY_I;
                    last_grant_nxt = GRANT_I;
                    cnt_nxt        = '0;
                    l2_req_nxt     = 1'b1;
                    l2_we_nxt      = 1'b0;
                    l2_addr_nxt    = i_addr;
                    l2_wdata_nxt   = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (l2_ack) begin
                    state_nxt  = DONE;
                    l2_req_nxt = 1'b0;
                    if (state == BUSY_I) begin
                        i_valid_nxt = 1'b1;
                        i_block_nxt = l2_rdata;
                    end else begin
                        d_valid_nxt = 1'b1;
                        if (!l2_we) d_block_nxt = l2_rdata;
                    end
                end else begin
                    // Saturating wait counter; err is sticky, request stays up
                    if (cnt != CNT_W'(TIMEOUT)) cnt_nxt = cnt + CNT_W'(1);
                    if (cnt_nxt == CNT_W'(TIMEOUT)) err_nxt = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter: cycle-exact checks of grant order, handshake,
// valid/stall timing, timeout flag and asynchronous reset.
module tb_l2_port_arbiter;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BLOCK_W = 128;

    logic               clk = 1'b0;
    logic               rst;
    logic               i_req;
    logic [ADDR_W-1:0]  i_addr;
    logic               i_stall, i_valid;
    logic [BLOCK_W-1:0] i_block;
    logic               d_req, d_we;
    logic [ADDR_W-1:0]  d_addr;
    logic [WORD_W-1:0]  d_wdata;
    logic               d_stall, d_valid;
    logic [BLOCK_W-1:0] d_block;
    logic               l2_req, l2_we;
    logic [ADDR_W-1:0]  l2_addr;
    logic [WORD_W-1:0]  l2_wdata;
    logic               l2_ack;
    logic [BLOCK_W-1:0] l2_rdata;
    logic               err;

    int vec  = 0;
    int miss = 0;

    l2_port_arbiter #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .BLOCK_W(BLOCK_W), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_stall(i_stall), .i_valid(i_valid), .i_block(i_block),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_stall(d_stall), .d_valid(d_valid), .d_block(d_block),
        .l2_req(l2_req), .l2_we(l2_we), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
        .l2_ack(l2_ack), .l2_rdata(l2_rdata), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
        $fatal(1);
    end

    // Advance to just after the next rising edge: start of the next cycle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        l2_ack = 0; l2_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        vec++; if ({l2_req, l2_we, i_valid, d_valid, err, i_stall, d_stall} !== 7'b0) begin
            miss++; $display("FAIL reset_flags got %b exp 0000000",
                             {l2_req, l2_we, i_valid, d_valid, err, i_stall, d_stall}); end
        vec++; if (l2_addr !== '0 || l2_wdata !== '0) begin
            miss++; $display("FAIL reset_l2_bus got addr=%h wdata=%h exp 0", l2_addr, l2_wdata); end
        vec++; if (i_block !== '0 || d_block !== '0) begin
            miss++; $display("FAIL reset_blocks got i=%h d=%h exp 0", i_block, d_block); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_i_read();
        logic [BLOCK_W-1:0] rd;
        rd = {32'h3, 32'h2, 32'h1, 32'h0};
        i_req = 1; i_addr = 32'h40;
        #1;
        vec++; if (i_stall !== 1'b1) begin miss++; $display("FAIL t1_stall_c0 got %b exp 1", i_stall); end
        tick(); // c1
        vec++; if (l2_req !== 1'b1 || l2_addr !== 32'h40 || l2_we !== 1'b0) begin
            miss++; $display("FAIL t1_l2_c1 got req=%b addr=%h we=%b exp 1 40 0", l2_req, l2_addr, l2_we); end
        vec++; if (i_valid !== 1'b0 || i_stall !== 1'b1) begin
            miss++; $display("FAIL t1_valid_c1 got valid=%b stall=%b exp 0 1", i_valid, i_stall); end
        tick(); // c2
        i_addr = 32'h7777;
        tick(); // c3
        vec++; if (l2_req !== 1'b1 || l2_addr !== 32'h40 || i_stall !== 1'b1) begin
            miss++; $display("FAIL t1_hold_c3 got req=%b addr=%h stall=%b exp 1 40 1", l2_req, l2_addr, i_stall); end
        l2_ack = 1; l2_rdata = rd;
        tick(); // c4
        l2_ack = 0; l2_rdata = '0;
        vec++; if (i_valid !== 1'b1 || i_block !== rd) begin
            miss++; $display("FAIL t1_valid_c4 got valid=%b block=%h exp 1 %h", i_valid, i_block, rd); end
        vec++; if (l2_req !== 1'b0 || i_stall !== 1'b0) begin
            miss++; $display("FAIL t1_drop_c4 got req=%b stall=%b exp 0 0", l2_req, i_stall); end
        i_req = 0;
        tick(); // c5
        vec++; if (i_valid !== 1'b0 || l2_req !== 1'b0) begin
            miss++; $display("FAIL t1_c5 got valid=%b req=%b exp 0 0", i_valid, l2_req); end
    endtask

    task automatic test_tie_round_robin();
        i_req = 1; i_addr = 32'h200;
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
        tick(); // c1: D wins first tie
        vec++; if (l2_req !== 1'b1 || l2_we !== 1'b1 || l2_addr !== 32'h100 || l2_wdata !== 32'hDEADBEEF) begin
            miss++; $display("FAIL t2_first_grant got req=%b we=%b addr=%h wdata=%h exp 1 1 100 deadbeef",
                             l2_req, l2_we, l2_addr, l2_wdata); end
        l2_ack = 1; l2_rdata = {4{32'hAAAA5555}};
        tick(); // c2
        l2_ack = 0;
        vec++; if (d_valid !== 1'b1 || d_stall !== 1'b0 || i_stall !== 1'b1 || i_valid !== 1'b0) begin
            miss++; $display("FAIL t2_d_done got dv=%b ds=%b is=%b iv=%b exp 1 0 1 0",
                             d_valid, d_stall, i_stall, i_valid); end
        vec++; if (d_block !== '0) begin
            miss++; $display("FAIL t2_write_block got %h exp 0", d_block); end
        tick(); // c3 IDLE, both held
        vec++; if (l2_req !== 1'b0) begin miss++; $display("FAIL t2_done_gap got %b exp 0", l2_req); end
        tick(); // c4: I wins the tie
        vec++; if (l2_req !== 1'b1 || l2_we !== 1'b0 || l2_addr !== 32'h200 || l2_wdata !== 32'h0) begin
            miss++; $display("FAIL t2_second_grant got req=%b we=%b addr=%h wdata=%h exp 1 0 200 0",
                             l2_req, l2_we, l2_addr, l2_wdata); end
        l2_ack = 1; l2_rdata = {4{32'h12345678}};
        tick(); // c5
        l2_ack = 0;
        vec++; if (i_valid !== 1'b1 || i_block !== {4{32'h12345678}} || d_valid !== 1'b0) begin
            miss++; $display("FAIL t2_i_done got iv=%b blk=%h dv=%b exp 1 %h 0",
                             i_valid, i_block, d_valid, {4{32'h12345678}}); end
        tick(); // c6 IDLE, both still held
        tick(); // c7: alternation back to D
        vec++; if (l2_req !== 1'b1 || l2_we !== 1'b1 || l2_addr !== 32'h100) begin
            miss++; $display("FAIL t2_third_grant got req=%b we=%b addr=%h exp 1 1 100", l2_req, l2_we, l2_addr); end
        l2_ack = 1;
        tick(); // c8
        l2_ack = 0; l2_rdata = '0;
        vec++; if (d_valid !== 1'b1) begin miss++; $display("FAIL t2_third_done got %b exp 1", d_valid); end
        i_req = 0; d_req = 0; d_we = 0; d_wdata = '0;
        tick(); // c9
    endtask

    task automatic test_back_to_back();
        logic [BLOCK_W-1:0] r1, r2;
        r1 = {32'h11, 32'h22, 32'h33, 32'h44};
        r2 = {32'hA1, 32'hB2, 32'hC3, 32'hD4};
        d_req = 1; d_we = 0; d_addr = 32'h1000;
        tick(); // c1
        vec++; if (l2_req !== 1'b1 || l2_addr !== 32'h1000 || l2_we !== 1'b0) begin
            miss++; $display("FAIL t3_grant1 got req=%b addr=%h we=%b exp 1 1000 0", l2_req, l2_addr, l2_we); end
        tick(); // c2
        tick(); // c3
        vec++; if (d_stall !== 1'b1) begin miss++; $display("FAIL t3_stall_c3 got %b exp 1", d_stall); end
        l2_ack = 1; l2_rdata = r1;
        tick(); // c4
        l2_ack = 0; l2_rdata = '0;
        vec++; if (d_valid !== 1'b1 || d_block !== r1 || d_stall !== 1'b0) begin
            miss++; $display("FAIL t3_valid1 got v=%b blk=%h st=%b exp 1 %h 0", d_valid, d_block, d_stall, r1); end
        d_addr = 32'h2000;
        tick(); // c5
        vec++; if (l2_req !== 1'b0 || d_valid !== 1'b0) begin
            miss++; $display("FAIL t3_c5 got req=%b valid=%b exp 0 0", l2_req, d_valid); end
        tick(); // c6
        vec++; if (l2_req !== 1'b1 || l2_addr !== 32'h2000) begin
            miss++; $display("FAIL t3_grant2 got req=%b addr=%h exp 1 2000", l2_req, l2_addr); end
        l2_ack = 1; l2_rdata = r2;
        tick(); // c7
        l2_ack = 0; l2_rdata = '0;
        vec++; if (d_valid !== 1'b1 || d_block !== r2) begin
            miss++; $display("FAIL t3_valid2 got v=%b blk=%h exp 1 %h", d_valid, d_block, r2); end
        d_req = 0;
        tick(); // c8
    endtask

    task automatic test_stray_ack();
        logic [BLOCK_W-1:0] before_i, before_d;
        before_i = i_block;
        before_d = d_block;
        l2_ack = 1; l2_rdata = {4{32'hFFFF0000}};
        tick(); // c1
        l2_ack = 0; l2_rdata = '0;
        vec++; if (i_valid !== 1'b0 || d_valid !== 1'b0 || l2_req !== 1'b0) begin
            miss++; $display("FAIL t6_stray_c1 got iv=%b dv=%b req=%b exp 0 0 0", i_valid, d_valid, l2_req); end
        vec++; if (i_block !== before_i || d_block !== before_d) begin
            miss++; $display("FAIL t6_blocks got i=%h d=%h exp %h %h", i_block, d_block, before_i, before_d); end
        // A fresh request must be granted with idle latency
        i_req = 1; i_addr = 32'h60;
        tick(); // c2
        vec++; if (l2_req !== 1'b1 || l2_addr !== 32'h60) begin
            miss++; $display("FAIL t6_idle_grant got req=%b addr=%h exp 1 60", l2_req, l2_addr); end
        l2_ack = 1;
        tick();
        l2_ack = 0;
        vec++; if (i_valid !== 1'b1) begin miss++; $display("FAIL t6_done got %b exp 1", i_valid); end
        i_req = 0;
        tick();
    endtask

    task automatic test_timeout();
        i_req = 1; i_addr = 32'h900;
        tick(); // c1: first BUSY cycle
        vec++; if (l2_req !== 1'b1 || err !== 1'b0) begin
            miss++; $display("FAIL t4_c1 got req=%b err=%b exp 1 0", l2_req, err); end
        repeat (6) tick(); // c7
        vec++; if (err !== 1'b0) begin miss++; $display("FAIL t4_err_early got %b exp 0", err); end
        repeat (2) tick(); // c9
        vec++; if (err !== 1'b1 || l2_req !== 1'b1) begin
            miss++; $display("FAIL t4_err_set got err=%b req=%b exp 1 1", err, l2_req); end
        repeat (3) tick(); // c12
        vec++; if (err !== 1'b1 || l2_req !== 1'b1 || l2_addr !== 32'h900) begin
            miss++; $display("FAIL t4_held got err=%b req=%b addr=%h exp 1 1 900", err, l2_req, l2_addr); end
        l2_ack = 1; l2_rdata = {4{32'hC0FFEE00}};
        tick(); // c13
        l2_ack = 0; l2_rdata = '0;
        vec++; if (i_valid !== 1'b1 || i_block !== {4{32'hC0FFEE00}} || err !== 1'b1) begin
            miss++; $display("FAIL t4_late_ack got v=%b blk=%h err=%b exp 1 %h 1",
                             i_valid, i_block, err, {4{32'hC0FFEE00}}); end
        i_req = 0;
        tick(); // c14
        vec++; if (l2_req !== 1'b0 || err !== 1'b1) begin
            miss++; $display("FAIL t4_sticky got req=%b err=%b exp 0 1", l2_req, err); end
    endtask

    task automatic test_reset_mid_busy();
        logic [BLOCK_W-1:0] rd;
        rd = {32'h9, 32'h8, 32'h7, 32'h6};
        d_req = 1; d_we = 0; d_addr = 32'h500;
        tick(); // c1 BUSY_D
        vec++; if (l2_req !== 1'b1) begin miss++; $display("FAIL t5_busy got %b exp 1", l2_req); end
        #2 rst = 1'b1;
        #1;
        vec++; if (l2_req !== 1'b0 || d_valid !== 1'b0 || err !== 1'b0) begin
            miss++; $display("FAIL t5_async got req=%b dv=%b err=%b exp 0 0 0", l2_req, d_valid, err); end
        d_req = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick(); // c0
        i_req = 1; i_addr = 32'h80;
        tick(); // c1
        vec++; if (l2_req !== 1'b1 || l2_addr !== 32'h80 || l2_we !== 1'b0) begin
            miss++; $display("FAIL t5_grant got req=%b addr=%h we=%b exp 1 80 0", l2_req, l2_addr, l2_we); end
        tick(); // c2
        tick(); // c3
        l2_ack = 1; l2_rdata = rd;
        tick(); // c4
        l2_ack = 0; l2_rdata = '0;
        vec++; if (i_valid !== 1'b1 || i_block !== rd || d_valid !== 1'b0) begin
            miss++; $display("FAIL t5_done got iv=%b blk=%h dv=%b exp 1 %h 0", i_valid, i_block, d_valid, rd); end
        i_req = 0;
        tick(); // c5
        vec++; if (i_valid !== 1'b0) begin miss++; $display("FAIL t5_pulse got %b exp 0", i_valid); end
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_reset();
        test_tie_round_robin();
        test_back_to_back();
        test_stray_ack();
        test_timeout();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
